usb_ls_rx: RTL and testbench
============================

# usb_ls_rx

Low-speed (1.5 Mbit/s) USB receive front end for the HID host. It samples the raw D+/D- pair at 7.5 MHz (5x oversampling) and recovers bit timing with a phase counter that realigns on every line transition. It then NRZI-decodes, strips stuffed bits, detects SYNC and EOP, and delivers received packet bytes to the host transaction engine on a strobe interface. It sits between the bidirectional USB_DATA pins and the packet/PID layer of usbhid_host.

## Interface
- SAMPLES_PER_BIT, 5: clk cycles per USB bit time (7.5 MHz / 1.5 MHz).
- SAMPLE_PHASE, 2: phase-counter value at which the line is sampled (bit centre).
- clk  in  1  7.5 MHz system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low; low clears all state immediately.
- usb_data  in  2  raw line: [1]=D+, [0]=D-; asynchronous to clk.
- rx_enable  in  1  high = receive permitted; low while the host drives the bus.
- rx_data  out  8  received byte, LSB = first bit on the wire.
- rx_valid  out  1  one-cycle strobe; rx_data valid this cycle.
- rx_active  out  1  high from SYNC completion until EOP/abort.
- rx_eop  out  1  one-cycle strobe at end of packet.
- rx_err  out  1  one-cycle strobe: stuff error, SE1, or non-byte-aligned EOP.

## Operation
- Line states after a 2-flop synchroniser: J = 2'b01 (low-speed idle), K = 2'b10, SE0 = 2'b00, SE1 = 2'b11.
- DPLL:
  - Phase counter runs 0..SAMPLES_PER_BIT-1 and wraps.
  - A change in synchronised line state forces the phase to 0 on the next cycle.
  - The sample point is phase == SAMPLE_PHASE.
- NRZI: at each sample point, decoded bit = 1 if the line is unchanged from the previous sample, 0 if it changed.
- Bit unstuffing: count consecutive decoded 1s. After six 1s the next bit must be 0; that bit is dropped and the count cleared. A seventh 1 is a stuff error.
- State machine:
  - IDLE: phase counter held at 0; waits for J->K. Then go to SYNC and clear the zero counter.
  - SYNC: counts decoded 0s. A decoded 1 after ≥3 zeros completes SYNC: go to DATA, raise rx_active, clear the bit count. A 1 after <3 zeros, or SE0, returns to IDLE silently.
  - DATA: shifts unstuffed bits in LSB-first. On the 8th bit, rx_data is loaded and rx_valid pulses. SE0 at a sample point goes to EOP_WAIT. SE1 or a stuff error raises rx_err and goes to IDLE.
  - EOP_WAIT: waits for J. Then rx_eop pulses, rx_active drops, and the state returns to IDLE. rx_err also pulses if the bit count != 0 at SE0. SE0 lasting >4 bit times is treated as bus reset: go to IDLE without rx_eop.
- rx_enable low in any state: go to IDLE next cycle, rx_active low, no rx_eop, no rx_err. Partial data is discarded.
- A stuffed 0 that arrives as bit 8's successor is still dropped; stuffing spans byte boundaries.

## Timing
- Reset values: rx_data = 8'h00; rx_valid, rx_active, rx_eop and rx_err all 0; state IDLE; synchroniser flops = J.
- Input latency: 2 cycles (synchroniser) plus SAMPLE_PHASE cycles to the sample point.
- rx_valid asserts the cycle after the sample point of a byte's 8th bit. rx_data holds until the next rx_valid.
- rx_active rises the cycle after the SYNC-terminating 1 is sampled.
- rx_eop and rx_active-fall occur in the same cycle, the cycle after J is first seen post-SE0.
- rx_valid and rx_eop never share a cycle. rx_err may coincide with rx_eop (misaligned EOP).
- Jitter tolerance: any mix of 4-, 5- and 6-cycle bits decodes correctly, because each transition realigns the phase.
- Asynchronous reset mid-packet clears all outputs within the reset assertion. No strobe is emitted on release.

## Test plan
- SYNC + 0xC3 + 0x00 + 2-bit SE0 + J, 5 cycles/bit -> rx_valid twice (0xC3, 0x00), then one rx_eop, rx_err never set.
- Byte 0xFF with a stuffed 0 inserted after bit 6 -> rx_data = 0xFF, stuffed bit discarded, rx_err = 0.
- Seven consecutive 1s with no stuffed bit -> rx_err pulse, rx_active low next cycle, no rx_valid for that byte.
- SYNC + 4 data bits + SE0 + J -> rx_eop and rx_err pulse together, no rx_valid.
- SYNC + 0x5A with bit widths alternating 4/6 cycles -> rx_data = 0x5A, rx_err = 0.
- rx_enable held low during a full packet -> no rx_valid/rx_eop/rx_err. Then reset pulled low mid-packet -> all outputs 0, state IDLE.

Source files
------------

// File: rtl/usb_ls_rx.sv
// Low-speed USB receive front end: synchroniser, 5x oversampling DPLL, NRZI decode,
// bit unstuffing, SYNC/EOP detection and byte strobe delivery.
module usb_ls_rx #(
    parameter int unsigned SAMPLES_PER_BIT = 5,
    parameter int unsigned SAMPLE_PHASE    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] usb_data,
    input  logic       rx_enable,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_active,
    output logic       rx_eop,
    output logic       rx_err
);

    localparam int unsigned PW        = $clog2(SAMPLES_PER_BIT);
    localparam int unsigned EOP_LIMIT = 4 * SAMPLES_PER_BIT;
    localparam int unsigned EW        = $clog2(EOP_LIMIT + 1);

    localparam logic [1:0] LS_J   = 2'b01;
    localparam logic [1:0] LS_K   = 2'b10;
    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_SE1 = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA, S_EOP_WAIT} state_t;

    state_t        state, state_n;
    logic [1:0]    sync1, line, line_d;
    logic [1:0]    last_smp, last_smp_n;
    logic [PW-1:0] phase, phase_n;
    logic [1:0]    zeros, zeros_n;
    logic [2:0]    ones, ones_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shreg, shreg_n;
    logic [EW-1:0] eop_cnt, eop_cnt_n;
    logic          eop_err, eop_err_n;
    logic [7:0]    rx_data_n;
    logic          rx_valid_n, rx_active_n, rx_eop_n, rx_err_n;

    logic       chg_c, start_c, sample_c, dbit_c;
    logic [7:0] shifted_c;

    assign chg_c     = (sync1 != line);
    assign start_c   = rx_enable && (line == LS_K) && (line_d == LS_J);
    assign sample_c  = (state != S_IDLE) && (phase == PW'(SAMPLE_PHASE));
    assign dbit_c    = (line == last_smp);
    assign shifted_c = {dbit_c, shreg[7:1]};

    // Next-state, datapath and output logic
    always_comb begin
        state_n     = state;
        last_smp_n  = last_smp;
        zeros_n     = zeros;
        ones_n      = ones;
        bit_cnt_n   = bit_cnt;
        shreg_n     = shreg;
        eop_cnt_n   = eop_cnt;
        eop_err_n   = eop_err;
        rx_data_n   = rx_data;
        rx_valid_n  = 1'b0;
        rx_active_n = rx_active;
        rx_eop_n    = 1'b0;
        rx_err_n    = 1'b0;
        phase_n     = '0;

        if (sample_c) last_smp_n = line;

        case (state)
            S_IDLE: begin
                last_smp_n  = LS_J;
                rx_active_n = 1'b0;
                if (start_c) begin
                    state_n = S_SYNC;
                    zeros_n = 2'd0;
                end
            end
            S_SYNC: begin
                if (sample_c) begin
                    if (line == LS_SE0 || line == LS_SE1) begin
                        state_n = S_IDLE;
                    end else if (!dbit_c) begin
                        zeros_n = (zeros == 2'd3) ? 2'd3 : zeros + 2'd1;
                    end else if (zeros == 2'd3) begin
                        state_n     = S_DATA;
                        rx_active_n = 1'b1;
                        bit_cnt_n   = 3'd0;
                        ones_n      = 3'd0;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (sample_c) begin
                    if (line == LS_SE0) begin
                        state_n   = S_EOP_WAIT;
                        eop_err_n = (bit_cnt != 3'd0);
                        eop_cnt_n = '0;
                    end else if (line == LS_SE1 || (ones == 3'd6 && dbit_c)) begin
                        state_n     = S_IDLE;
                        rx_err_n    = 1'b1;
                        rx_active_n = 1'b0;
                    end else if (ones == 3'd6) begin
                        ones_n = 3'd0;  // stuffed zero: dropped
                    end else begin
                        ones_n    = dbit_c ? ones + 3'd1 : 3'd0;
                        shreg_n   = shifted_c;
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_data_n  = shifted_c;
                            rx_valid_n = 1'b1;
                        end
                    end
                end
            end
            S_EOP_WAIT: begin
                if (line == LS_J) begin
                    state_n     = S_IDLE;
                    rx_eop_n    = 1'b1;
                    rx_err_n    = eop_err;
                    rx_active_n = 1'b0;
                end else if (eop_cnt == EW'(EOP_LIMIT - 1)) begin
                    state_n     = S_IDLE;  // long SE0 is a bus reset
                    rx_active_n = 1'b0;
                end else begin
                    eop_cnt_n = eop_cnt + EW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (!rx_enable) begin
            state_n     = S_IDLE;
            rx_active_n = 1'b0;
            rx_valid_n  = 1'b0;
            rx_eop_n    = 1'b0;
            rx_err_n    = 1'b0;
        end

        // DPLL: realign on every line change, free-run otherwise
        if (state_n == S_IDLE || chg_c)                  phase_n = '0;
        else if (phase == PW'(SAMPLES_PER_BIT - 1))      phase_n = '0;
        else                                             phase_n = phase + PW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1     <= LS_J;
            line      <= LS_J;
            line_d    <= LS_J;
            last_smp  <= LS_J;
            state     <= S_IDLE;
            phase     <= '0;
            zeros     <= 2'd0;
            ones      <= 3'd0;
            bit_cnt   <= 3'd0;
            shreg     <= 8'h00;
            eop_cnt   <= '0;
            eop_err   <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            rx_active <= 1'b0;
            rx_eop    <= 1'b0;
            rx_err    <= 1'b0;
        end else begin
            sync1     <= usb_data;
            line      <= sync1;
            line_d    <= line;
            last_smp  <= last_smp_n;
            state     <= state_n;
            phase     <= phase_n;
            zeros     <= zeros_n;
            ones      <= ones_n;
            bit_cnt   <= bit_cnt_n;
            shreg     <= shreg_n;
            eop_cnt   <= eop_cnt_n;
            eop_err   <= eop_err_n;
            rx_data   <= rx_data_n;
            rx_valid  <= rx_valid_n;
            rx_active <= rx_active_n;
            rx_eop    <= rx_eop_n;
            rx_err    <= rx_err_n;
        end
    end

endmodule

// File: tb/tb_usb_ls_rx.sv
// Scoreboard bench for usb_ls_rx: NRZI line driver pushes expected strobes, a
// negedge monitor pops and compares whenever the receiver emits one.
module tb_usb_ls_rx;

    localparam logic [1:0] J   = 2'b01;
    localparam logic [1:0] K   = 2'b10;
    localparam logic [1:0] SE0 = 2'b00;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] usb_data;
    logic       rx_enable;
    logic [7:0] rx_data;
    logic       rx_valid, rx_active, rx_eop, rx_err;

    usb_ls_rx dut (
        .clk       (clk),
        .reset     (reset),
        .usb_data  (usb_data),
        .rx_enable (rx_enable),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_active (rx_active),
        .rx_eop    (rx_eop),
        .rx_err    (rx_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       valid;
        logic       eop;
        logic       err;
        logic [7:0] data;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    logic [1:0] cur = J;
    bit         jitter = 1'b0;
    int         bidx = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic push(input logic v, input logic e, input logic r, input logic [7:0] d);
        exp_t x;
        x.valid = v; x.eop = e; x.err = r; x.data = d;
        q.push_back(x);
    endtask

    task automatic drive(input logic [1:0] ls, input int n);
        usb_data = ls;
        repeat (n) @(negedge clk);
    endtask

    task automatic tx_bit(input logic b);
        int w;
        w = jitter ? ((bidx % 2 == 0) ? 4 : 6) : 5;
        bidx++;
        if (!b) cur = (cur == J) ? K : J;
        drive(cur, w);
    endtask

    task automatic tx_sync();
        for (int i = 0; i < 7; i++) tx_bit(1'b0);
        tx_bit(1'b1);
    endtask

    task automatic tx_byte(input logic [7:0] b);
        logic [7:0] v;
        v = b;
        for (int i = 0; i < 8; i++) tx_bit(v[i]);
    endtask

    task automatic tx_eop();
        drive(SE0, 10);
        cur = J;
        drive(J, 10);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
        check(name, 32'(q.size()), 32'd0);
    endtask

    // Monitor: every strobe cycle is matched against the head of the queue
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1 && (rx_valid || rx_eop || rx_err)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got valid=%0b eop=%0b err=%0b data=%0h, required none",
                         rx_valid, rx_eop, rx_err, rx_data);
            end else begin
                e = q.pop_front();
                check("rx_valid", 32'(rx_valid), 32'(e.valid));
                check("rx_eop", 32'(rx_eop), 32'(e.eop));
                check("rx_err", 32'(rx_err), 32'(e.err));
                if (e.valid) begin
                    check("rx_data", 32'(rx_data), 32'(e.data));
                    check("rx_active_with_valid", 32'(rx_active), 32'd1);
                end else begin
                    check("rx_active_at_end", 32'(rx_active), 32'd0);
                end
            end
        end
    end

    initial begin
        reset     = 1'b0;
        rx_enable = 1'b1;
        usb_data  = J;
        repeat (3) @(negedge clk);
        check("reset_rx_data", 32'(rx_data), 32'h00);
        check("reset_strobes", 32'({rx_valid, rx_active, rx_eop, rx_err}), 32'd0);
        reset = 1'b1;
        drive(J, 10);

        // Two-byte packet, nominal bit width
        push(1'b1, 1'b0, 1'b0, 8'hC3);
        push(1'b1, 1'b0, 1'b0, 8'h00);
        push(1'b0, 1'b1, 1'b0, 8'h00);
        tx_sync();
        tx_byte(8'hC3);
        check("active_mid_packet", 32'(rx_active), 32'd1);
        tx_byte(8'h00);
        tx_eop();
        drain("drain_two_bytes");
        check("active_after_eop", 32'(rx_active), 32'd0);

        // 0xFF with a stuffed zero after six ones
        push(1'b1, 1'b0, 1'b0, 8'hFF);
        push(1'b0, 1'b1, 1'b0, 8'h00);
        tx_sync();
        for (int i = 0; i < 6; i++) tx_bit(1'b1);
        tx_bit(1'b0);
        tx_bit(1'b1);
        tx_bit(1'b1);
        tx_eop();
        drain("drain_stuffed");

        // Seven ones: stuff error, no byte
        push(1'b0, 1'b0, 1'b1, 8'h00);
        tx_sync();
        for (int i = 0; i < 7; i++) tx_bit(1'b1);
        cur = J;
        drive(J, 10);
        drain("drain_stuff_err");
        check("active_after_stuff_err", 32'(rx_active), 32'd0);

        // Four data bits then EOP: misaligned end
        push(1'b0, 1'b1, 1'b1, 8'h00);
        tx_sync();
        tx_bit(1'b1); tx_bit(1'b0); tx_bit(1'b1); tx_bit(1'b0);
        tx_eop();
        drain("drain_misaligned");

        // 0x5A with bit widths alternating 4/6 cycles
        push(1'b1, 1'b0, 1'b0, 8'h5A);
        push(1'b0, 1'b1, 1'b0, 8'h00);
        jitter = 1'b1;
        bidx   = 0;
        tx_sync();
        tx_byte(8'h5A);
        jitter = 1'b0;
        tx_eop();
        drain("drain_jitter");

        // Receiver disabled for a whole packet: nothing expected
        rx_enable = 1'b0;
        tx_sync();
        tx_byte(8'hC3);
        check("active_while_disabled", 32'(rx_active), 32'd0);
        tx_byte(8'h00);
        tx_eop();
        rx_enable = 1'b1;
        drive(J, 10);
        check("data_kept_after_disabled", 32'(rx_data), 32'h5A);

        // Asynchronous reset in the middle of a packet
        tx_sync();
        tx_bit(1'b1); tx_bit(1'b0); tx_bit(1'b1);
        check("active_before_reset", 32'(rx_active), 32'd1);
        reset = 1'b0;
        #1;
        check("reset_mid_rx_data", 32'(rx_data), 32'h00);
        check("reset_mid_strobes", 32'({rx_valid, rx_active, rx_eop, rx_err}), 32'd0);
        cur = J;
        drive(J, 3);
        reset = 1'b1;
        drive(J, 10);
        check("post_reset_quiet", 32'({rx_valid, rx_active, rx_eop, rx_err}), 32'd0);

        // Receiver back from reset in IDLE and decoding normally
        push(1'b1, 1'b0, 1'b0, 8'h3C);
        push(1'b0, 1'b1, 1'b0, 8'h00);
        tx_sync();
        tx_byte(8'h3C);
        tx_eop();
        drain("drain_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
